// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: load/store size codes, FSM states and
// small helpers for size normalisation, lane offset and misalignment.
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_e;

   // Unknown funct3 codes behave as a full word.
   function automatic logic [2:0] norm_size(input logic [2:0] i_size);
      logic [2:0] v;
      case (i_size)
         LDST_B, LDST_H, LDST_BU, LDST_HU: v = i_size;
         default:                          v = LDST_W;
      endcase
      return v;
   endfunction

   // Byte offset actually used; illegal low bits are dropped.
   function automatic logic [1:0] eff_offset(input logic [2:0] i_size,
                                             input logic [1:0] i_lo);
      logic [1:0] v;
      case (i_size)
         LDST_B, LDST_BU: v = i_lo;
         LDST_H, LDST_HU: v = {i_lo[1], 1'b0};
         default:         v = 2'b00;
      endcase
      return v;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] i_size,
                                          input logic [1:0] i_lo);
      logic v;
      case (i_size)
         LDST_B, LDST_BU: v = 1'b0;
         LDST_H, LDST_HU: v = i_lo[0];
         default:         v = (i_lo != 2'b00);
      endcase
      return v;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: shift the addressed lanes down, then
// sign- or zero-extend according to the load size.
module lsu_load_ext
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_size,
   output logic [31:0] o_data
);

   logic [31:0] w_shift;

   assign w_shift = i_rdata >> {i_offset, 3'b000};

   // Extend the selected byte/half; words pass through unshifted.
   always_comb begin
      o_data = i_rdata;
      case (i_size)
         LDST_B:  o_data = {{24{w_shift[7]}}, w_shift[7:0]};
         LDST_BU: o_data = {24'd0, w_shift[7:0]};
         LDST_H:  o_data = {{16{w_shift[15]}}, w_shift[15:0]};
         LDST_HU: o_data = {16'd0, w_shift[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_periph_master.sv
// Core load/store to peripheral bus initiator, 3-cycle access.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests trap instead of aligning.
module lsu_periph_master
   import riscv_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [2:0]        lsu_size_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic [DATA_W-1:0] lsu_data_o,
   output logic              lsu_stall_o,
   output logic              lsu_misalign_o,
   output logic              per_req_o,
   output logic              per_we_o,
   output logic [ADDR_W-1:0] per_addr_o,
   output logic [DATA_W-1:0] per_wdata_o,
   output logic [3:0]        per_mask_o,
   input  logic [DATA_W-1:0] per_rdata_i
);

   lsu_state_e        r_state;
   logic [2:0]        r_size;
   logic [1:0]        r_off;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_mask;
   logic [DATA_W-1:0] r_data;
   logic              r_mis;

   logic [2:0]        w_size;
   logic [1:0]        w_off;
   logic              w_trap;
   logic [3:0]        w_mask;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_ld;

   assign w_size = norm_size(lsu_size_i);
   assign w_off  = eff_offset(w_size, lsu_addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_trap = is_misaligned(w_size, lsu_addr_i[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   // Byte-lane mask and replicated write data for the new request.
   always_comb begin
      w_mask  = 4'b1111;
      w_wdata = '0;
      if (lsu_we_i) begin
         case (w_size)
            LDST_B, LDST_BU: begin
               w_mask  = 4'b0001 << w_off;
               w_wdata = {4{lsu_data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
               w_mask  = 4'b0011 << w_off;
               w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
               w_mask  = 4'b1111;
               w_wdata = lsu_data_i;
            end
         endcase
      end
   end

   lsu_load_ext u_ext (
      .i_rdata  (per_rdata_i),
      .i_offset (r_off),
      .i_size   (r_size),
      .o_data   (w_ld)
   );

   // Access FSM; bus outputs are registered and live only in ACCESS.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_size  <= '0;
         r_off   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_mask  <= '0;
         r_data  <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_mask  <= '0;
         r_mis   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (lsu_req_i && w_trap) begin
                  r_state <= DONE;
                  r_mis   <= 1'b1;
               end else if (lsu_req_i) begin
                  r_state <= ACCESS;
                  r_size  <= w_size;
                  r_off   <= w_off;
                  r_req   <= 1'b1;
                  r_we    <= lsu_we_i;
                  r_addr  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                  r_wdata <= w_wdata;
                  r_mask  <= w_mask;
               end
            end
            ACCESS: begin
               r_state <= DONE;
               if (!r_we)
                  r_data <= w_ld;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign lsu_stall_o    = (r_state == ACCESS) ||
                           ((r_state == IDLE) && lsu_req_i);
   assign lsu_misalign_o = r_mis;
   assign lsu_data_o     = r_data;
   assign per_req_o      = r_req;
   assign per_we_o       = r_we;
   assign per_addr_o     = r_addr;
   assign per_wdata_o    = r_wdata;
   assign per_mask_o     = r_mask;

endmodule

// File: tb/tb_lsu_periph_master.sv
// Scoreboard bench for lsu_periph_master: driver queues expected bus
// transactions, a negedge monitor pops and compares them.
module tb_lsu_periph_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        stall;
   logic        mis;
   logic        preq;
   logic        pwe;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pmask;
   logic [31:0] prdata;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] data;
   } exp_t;

   exp_t        bus_q[$];
   logic [31:0] mis_q[$];
   exp_t        e;
   logic [31:0] last_ld;
   logic        pend;
   logic [31:0] pend_data;
   logic [31:0] md;
   int          checks = 0;
   int          fails  = 0;

   always #5 clk = ~clk;

   lsu_periph_master dut (
      .clk            (clk),
      .reset          (reset),
      .lsu_req_i      (req),
      .lsu_we_i       (we),
      .lsu_size_i     (size),
      .lsu_addr_i     (addr),
      .lsu_data_i     (din),
      .lsu_data_o     (dout),
      .lsu_stall_o    (stall),
      .lsu_misalign_o (mis),
      .per_req_o      (preq),
      .per_we_o       (pwe),
      .per_addr_o     (paddr),
      .per_wdata_o    (pwdata),
      .per_mask_o     (pmask),
      .per_rdata_i    (prdata)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: bus transactions, DONE load data, misalign pulses.
   initial begin
      pend = 1'b0;
      pend_data = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("lsu_data_o in DONE", dout, pend_data);
            pend = 1'b0;
         end
         if (preq) begin
            if (bus_q.size() == 0) begin
               chk("unexpected per_req_o", {31'd0, preq}, 32'd0);
            end else begin
               e = bus_q.pop_front();
               chk("per_we_o", {31'd0, pwe}, {31'd0, e.we});
               chk("per_addr_o", paddr, e.addr);
               chk("per_mask_o", {28'd0, pmask}, {28'd0, e.mask});
               if (e.we)
                  chk("per_wdata_o", pwdata, e.wdata);
               pend = 1'b1;
               pend_data = e.data;
            end
         end else begin
            chk("idle bus zero", paddr | pwdata | {27'd0, pwe, pmask}, 32'd0);
         end
         if (mis) begin
            if (mis_q.size() == 0) begin
               chk("unexpected lsu_misalign_o", {31'd0, mis}, 32'd0);
            end else begin
               md = mis_q.pop_front();
               chk("lsu_data_o on misalign", dout, md);
            end
         end
      end
   end

   task automatic acc(input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input logic [31:0] xa,
                      input logic [31:0] xwd, input logic [3:0] xm,
                      input logic [31:0] xld, input int xstall,
                      input logic trap);
      exp_t x;
      int n;
      if (trap) begin
         mis_q.push_back(last_ld);
      end else begin
         if (!w)
            last_ld = xld;
         x.we = w;
         x.addr = xa;
         x.wdata = xwd;
         x.mask = xm;
         x.data = last_ld;
         bus_q.push_back(x);
      end
      @(negedge clk);
      req = 1'b1;
      we = w;
      size = sz;
      addr = a;
      din = d;
      prdata = rd;
      #1;
      n = 0;
      while (stall && n < 10) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("stall cycles", 32'(n), 32'(xstall));
      // Hold the request through DONE as the core does.
      @(posedge clk);
      #1;
      req = 1'b0;
      we = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " lsu_data_o"}, dout, 32'd0);
      chk({tag, " stall/mis/req"}, {29'd0, stall, mis, preq}, 32'd0);
      chk({tag, " bus"}, paddr | pwdata | {27'd0, pwe, pmask}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      req = 1'b0;
      we = 1'b0;
      size = 3'b000;
      addr = '0;
      din = '0;
      prdata = '0;
      last_ld = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // SW 0x84
      acc(1'b1, 3'b010, 32'h84, 32'hDEADBEEF, 32'h0,
          32'h84, 32'hDEADBEEF, 4'b1111, 32'h0, 2, 1'b0);
      // SB 0x86
      acc(1'b1, 3'b000, 32'h86, 32'h000000A5, 32'h0,
          32'h84, 32'hA5A5A5A5, 4'b0100, 32'h0, 2, 1'b0);
      // LB / LBU 0x87
      acc(1'b0, 3'b000, 32'h87, 32'h0, 32'h80FF1234,
          32'h84, 32'h0, 4'b1111, 32'hFFFFFF80, 2, 1'b0);
      acc(1'b0, 3'b100, 32'h87, 32'h0, 32'h80FF1234,
          32'h84, 32'h0, 4'b1111, 32'h00000080, 2, 1'b0);
      // LH / LHU 0x8A
      acc(1'b0, 3'b001, 32'h8A, 32'h0, 32'h80010000,
          32'h88, 32'h0, 4'b1111, 32'hFFFF8001, 2, 1'b0);
      acc(1'b0, 3'b101, 32'h8A, 32'h0, 32'h80010000,
          32'h88, 32'h0, 4'b1111, 32'h00008001, 2, 1'b0);
      // SH 0x8A: lsu_data_o must keep the last load value
      acc(1'b1, 3'b001, 32'h8A, 32'h00001234, 32'h0,
          32'h88, 32'h12341234, 4'b1100, 32'h0, 2, 1'b0);
      // Unknown size 3'b111 acts as LW
      acc(1'b0, 3'b111, 32'h88, 32'h0, 32'h89ABCDEF,
          32'h88, 32'h0, 4'b1111, 32'h89ABCDEF, 2, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      // LW 0x85 and SH 0x81 trap
      acc(1'b0, 3'b010, 32'h85, 32'h0, 32'h11223344,
          32'h0, 32'h0, 4'b0000, 32'h0, 1, 1'b1);
      acc(1'b1, 3'b001, 32'h81, 32'h0000BEEF, 32'h0,
          32'h0, 32'h0, 4'b0000, 32'h0, 1, 1'b1);
`else
      // LW 0x85 forced to 0x84
      acc(1'b0, 3'b010, 32'h85, 32'h0, 32'h11223344,
          32'h84, 32'h0, 4'b1111, 32'h11223344, 2, 1'b0);
      // SH 0x81 forced to lanes 0-1
      acc(1'b1, 3'b001, 32'h81, 32'h0000BEEF, 32'h0,
          32'h80, 32'hBEEFBEEF, 4'b0011, 32'h0, 2, 1'b0);
      // LHU 0x8B forced to offset 2
      acc(1'b0, 3'b101, 32'h8B, 32'h0, 32'hCAFE0000,
          32'h88, 32'h0, 4'b1111, 32'h0000CAFE, 2, 1'b0);
`endif

      // Reset during ACCESS of SW 0x90
      e.we = 1'b1;
      e.addr = 32'h90;
      e.wdata = 32'h00000055;
      e.mask = 4'b1111;
      e.data = 32'h0;
      bus_q.push_back(e);
      last_ld = '0;
      @(negedge clk);
      req = 1'b1;
      we = 1'b1;
      size = 3'b010;
      addr = 32'h90;
      din = 32'h00000055;
      @(negedge clk);
      #1;
      reset = 1'b1;
      req = 1'b0;
      we = 1'b0;
      @(negedge clk);
      #1;
      chk_all_zero("abort");
      reset = 1'b0;
      repeat (4) @(negedge clk);

      #1;
      chk("bus queue drained", 32'(bus_q.size()), 32'd0);
      chk("misalign queue drained", 32'(mis_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
